// File: rtl/alu_cmd_issuer_pkg.sv
// Purpose: shared types and constants for the ALU command issuer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_cmd_issuer_pkg;

    // Datapath width of operands, accumulator and result.
    localparam int DATA_W = 4;

    // Operation encodings carried on in_op.
    typedef enum logic [1:0] {
        OP_SRA = 2'b00,
        OP_SRL = 2'b01,
        OP_SUB = 2'b10,
        OP_ADD = 2'b11
    } op_t;

    // Issuer FSM states.
    //   IDLE  : FIFO empty and no result held
    //   RUN   : issuing and/or draining results
    //   STALL : result held under backpressure with commands still queued
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    // One queued command as stored in the FIFO.
    typedef struct packed {
        op_t               op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [1:0]        c;
        logic              chain;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_issuer_alu.sv
// Purpose: 4-bit combinational ALU (SRA, SRL, SUB, ADD), results wrap modulo 2^DATA_W.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: a/b operands, c shift amount, op selects the operation, ans is the result.
module alu_core
    import alu_cmd_issuer_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        c,
    input  op_t               op,
    output logic [DATA_W-1:0] ans
);

    // Signed view of A so >>> replicates the sign bit.
    logic signed [DATA_W-1:0] a_signed;
    assign a_signed = a;

    always_comb begin
        ans = '0;
        case (op)
            OP_SRA:  ans = a_signed >>> c;
            OP_SRL:  ans = a >> c;
            OP_SUB:  ans = a - b;
            OP_ADD:  ans = a + b;
            default: ans = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Purpose: queues ALU commands in a DEPTH-entry FIFO and issues them one per cycle into a held result register.
// Latency: command accepted at edge N is presented on out_valid/out_ans after edge N+1 when FIFO and result are empty.
// Backpressure: out_ready low holds the result stable and lets the FIFO fill; in_ready drops when the FIFO is full or clr is high.
// Ports:
//   clk, rst_n       single clock, asynchronous active-low reset
//   clr              synchronous flush of FIFO, result, accumulator and done counter; overrides everything that cycle
//   in_valid/in_ready command handshake; in_op/in_a/in_b/in_c/in_chain form the command
//   out_valid/out_ready result handshake; out_ans is the held result
//   done_cnt         count of completed result handshakes, wraps at 256
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_c,
    input  logic              in_chain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ans,
    output logic [7:0]        done_cnt
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_cmd_issuer: DEPTH must be a power of two in 2..16");
    end

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    cmd_t              mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       cnt_nxt;
    logic              ready_en;
    logic [DATA_W-1:0] acc;
    logic              vld_nxt;
    state_t            state;
    state_t            state_nxt;

    // ------------------------------------------------------------------
    // Handshake / control decode
    // ------------------------------------------------------------------
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              handoff;
    cmd_t              wr_cmd;
    cmd_t              head;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] alu_ans;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // ready_en is cleared by reset and set on the first clock edge after
    // release, so in_ready stays low throughout reset and rises one edge later.
    assign in_ready = ready_en && !full && !clr;
    assign push     = in_valid && in_ready;

    // clr suppresses issue and handoff so nothing is counted in a flush cycle.
    assign handoff  = out_valid && out_ready && !clr;
    assign pop      = !clr && !empty && (!out_valid || out_ready);

    always_comb begin
        wr_cmd       = '0;
        wr_cmd.op    = op_t'(in_op);
        wr_cmd.a     = in_a;
        wr_cmd.b     = in_b;
        wr_cmd.c     = in_c;
        wr_cmd.chain = in_chain;
    end

    assign head = mem[rd_ptr];

    // Chained commands take operand A from the previous issued result.
    assign opa  = head.chain ? acc : head.a;

    alu_core u_alu (
        .a   (opa),
        .b   (head.b),
        .c   (head.c),
        .op  (head.op),
        .ans (alu_ans)
    );

    // ------------------------------------------------------------------
    // Next-cycle occupancy, shared by the registers and the FSM
    // ------------------------------------------------------------------
    always_comb begin
        cnt_nxt = count;
        if (clr) begin
            cnt_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_nxt = count + (AW+1)'(1);
                2'b01:   cnt_nxt = count - (AW+1)'(1);
                default: cnt_nxt = count;
            endcase
        end
    end

    always_comb begin
        vld_nxt = out_valid;
        if (clr) begin
            vld_nxt = 1'b0;
        end else if (pop) begin
            vld_nxt = 1'b1;
        end else if (handoff) begin
            vld_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: only slots between rd_ptr and wr_ptr
    // are ever read for an issue)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_cmd;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_ans   <= '0;
            acc       <= '0;
            done_cnt  <= '0;
        end else begin
            ready_en  <= 1'b1;
            count     <= cnt_nxt;
            out_valid <= vld_nxt;
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                out_ans  <= '0;
                acc      <= '0;
                done_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + AW'(1);
                    out_ans <= alu_ans;
                    acc     <= alu_ans;
                end
                if (handoff) begin
                    done_cnt <= done_cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: tracks IDLE / RUN / STALL from next-cycle occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (cnt_nxt == '0 && !vld_nxt) begin
                        state_nxt = IDLE;
                    end else if (out_valid && !out_ready && cnt_nxt != '0) begin
                        state_nxt = STALL;
                    end
                end
                STALL: begin
                    if (out_ready) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // IDLE must always mean nothing queued and nothing held.
    a_idle_consistent: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == IDLE) |-> (!out_valid && empty)
    );

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_c;
    logic       in_chain;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_ans;
    logic [7:0] done_cnt;

    localparam logic [1:0] SRA = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SUB = 2'b10;
    localparam logic [1:0] ADD = 2'b11;

    int         tests;
    int         fails;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    alu_cmd_issuer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_chain  (in_chain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ans   (out_ans),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every result handshake pops one expected value.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got out_ans=%0h, expected no result", out_ans);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 32'(out_ans), 32'(mon_exp));
            end
        end
    end

    // Offer one command; returns at posedge+1 of the accepting edge.
    task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] c, input logic ch, input logic [3:0] expv);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_chain = ch;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("push_timeout", 32'(in_ready), 32'(1));
        end else begin
            @(posedge clk);
            exp_q.push_back(expv);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = 4'h0;
        in_b      = 4'h0;
        in_c      = 2'b00;
        in_chain  = 1'b0;
        out_ready = 1'b1;
        tests     = 0;
        fails     = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_ans", 32'(out_ans), 32'(0));
        check("rst_done_cnt", 32'(done_cnt), 32'(0));
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 32'(in_ready), 32'(1));

        // Latency: 7+9 wraps to 0, visible after the second edge
        push(ADD, 4'd7, 4'd9, 2'd0, 1'b0, 4'h0);
        check("lat_edge_n", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("lat_edge_n1_vld", 32'(out_valid), 32'(1));
        check("lat_edge_n1_ans", 32'(out_ans), 32'(0));

        // Basic operations
        push(SUB, 4'd3, 4'd5, 2'd0, 1'b0, 4'hE);
        push(SRA, 4'b1000, 4'd0, 2'd2, 1'b0, 4'b1110);
        push(SRL, 4'b1000, 4'd0, 2'd2, 1'b0, 4'b0010);

        // Chaining (in_a deliberately garbage on chained commands)
        push(ADD, 4'd3, 4'd2, 2'd0, 1'b0, 4'd5);
        push(ADD, 4'hF, 4'd1, 2'd0, 1'b1, 4'd6);
        push(SUB, 4'hF, 4'd6, 2'd0, 1'b1, 4'd0);
        wait_drain();

        // Zero the counter before the backpressure run
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_idle_done0", 32'(done_cnt), 32'(0));

        // Backpressure: 1 result held + 4 queued
        out_ready = 1'b0;
        push(ADD, 4'd1, 4'd1, 2'd0, 1'b0, 4'd2);
        push(ADD, 4'd1, 4'd2, 2'd0, 1'b0, 4'd3);
        push(SUB, 4'd9, 4'd1, 2'd0, 1'b0, 4'd8);
        push(SRL, 4'hF, 4'd0, 2'd1, 1'b0, 4'd7);
        push(SRA, 4'b0111, 4'd0, 2'd1, 1'b0, 4'b0011);
        check("bp_in_ready_full", 32'(in_ready), 32'(0));
        check("bp_out_valid", 32'(out_valid), 32'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_ans", 32'(out_ans), 32'(2));
            check("bp_hold_vld", 32'(out_valid), 32'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        check("bp_done_cnt", 32'(done_cnt), 32'(5));

        // clr with 3 queued, 1 held and a command offered
        out_ready = 1'b0;
        push(ADD, 4'd5, 4'd5, 2'd0, 1'b0, 4'hA);
        push(ADD, 4'd1, 4'd1, 2'd0, 1'b0, 4'd2);
        push(ADD, 4'd2, 4'd2, 2'd0, 1'b0, 4'd4);
        push(ADD, 4'd3, 4'd3, 2'd0, 1'b0, 4'd6);
        in_valid = 1'b1;
        in_op    = ADD;
        in_a     = 4'd1;
        in_b     = 4'd1;
        in_chain = 1'b0;
        clr      = 1'b1;
        #1;
        check("clr_no_accept", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("clr_out_valid", 32'(out_valid), 32'(0));
        check("clr_done_cnt", 32'(done_cnt), 32'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("clr_fifo_empty", 32'(out_valid), 32'(0));
        end
        @(posedge clk);
        #1;
        push(ADD, 4'hF, 4'd3, 2'd0, 1'b1, 4'd3);
        wait_drain();

        // Asynchronous reset mid-stream with 2 queued commands
        out_ready = 1'b0;
        push(ADD, 4'd4, 4'd4, 2'd0, 1'b0, 4'd8);
        push(SUB, 4'd1, 4'd1, 2'd0, 1'b0, 4'd0);
        push(ADD, 4'd6, 4'd6, 2'd0, 1'b0, 4'hC);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_out_ans", 32'(out_ans), 32'(0));
        check("arst_in_ready", 32'(in_ready), 32'(0));
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready_up", 32'(in_ready), 32'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("arst_no_stale", 32'(out_valid), 32'(0));
        end
        @(posedge clk);
        #1;
        push(ADD, 4'hF, 4'd4, 2'd0, 1'b1, 4'd4);
        push(ADD, 4'd9, 4'd9, 2'd0, 1'b0, 4'd2);
        wait_drain();
        check("arst_done_cnt", 32'(done_cnt), 32'(2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving command FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port clr  input  1  synchronous flush of FIFO, result, accumulator and counter.
REQ-005 The block SHALL have port in_valid  input  1  command offered.
REQ-006 The block SHALL have port in_ready  output  1  command accepted when in_valid and in_ready are both high at an edge.
REQ-007 The block SHALL have port in_op  input  2  00 arithmetic shift right, 01 logical shift right, 10 subtract, 11 add.
REQ-008 The block SHALL have port in_a  input  4  operand A.
REQ-009 The block SHALL have port in_b  input  4  operand B.
REQ-010 The block SHALL have port in_c  input  2  shift amount.
REQ-011 The block SHALL have port in_chain  input  1  use the accumulator instead of in_a as operand A.
REQ-012 The block SHALL have port out_valid  output  1  result held.
REQ-013 The block SHALL have port out_ready  input  1  consumer takes the result when out_valid and out_ready are both high.
REQ-014 The block SHALL have port out_ans  output  4  result value.
REQ-015 The block SHALL have port done_cnt  output  8  results handed off, wrapping from 255 to 0.

Function
REQ-016 Commands SHALL be stored in a DEPTH-entry FIFO, with in_ready = !full && !clr.
REQ-017 Issue SHALL occur when the FIFO is non-empty and the result register is empty or being emptied in the same cycle.
REQ-018 On issue, the head SHALL pop, the result register SHALL load the ALU output, out_valid SHALL be set, and acc SHALL load the same value.
REQ-019 Operand A SHALL be acc if chain=1, else in_a; acc SHALL be the value from the most recent issue.
REQ-020 Arithmetic SHALL be 4-bit and wrap modulo 16: SRA sign-fills, SRL zero-fills, sub = A-B, add = A+B; B is unused for shifts and C is unused for add/sub.
REQ-021 Latency: command accepted at edge N, out_valid high after edge N+1 if FIFO and result register were empty.
REQ-022 Throughput SHALL be one result per cycle while out_ready is held high.
REQ-023 out_ans and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 The FSM SHALL have states IDLE (FIFO empty, result empty), RUN (issuing or result draining), and STALL (out_valid=1, out_ready=0, FIFO full or non-empty).
REQ-025 The FSM transitions SHALL be: IDLE->RUN on accept; RUN->STALL on backpressure; STALL->RUN on out_ready; RUN->IDLE when both FIFO and result register empty; any state->IDLE on clr.
REQ-026 Simultaneous push and pop on a full FIFO SHALL be impossible because in_ready is low when full; simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH, with full/empty derived from a count or an extra pointer bit.
REQ-028 done_cnt SHALL increment on each out handshake.
REQ-029 clr SHALL take priority over every concurrent event: no accept, no issue, no count increment that cycle.

Reset
REQ-030 While rst_n=0, out_valid=0, out_ans=0, done_cnt=0, acc=0, FIFO empty, FSM=IDLE, and in_ready=0.
REQ-031 Reset asserted mid-operation SHALL discard queued commands and any held result immediately, with no partial handoff.
REQ-032 After rst_n deasserts, in_ready SHALL go high at the first edge.

Structure
REQ-033 A shared package SHALL hold the op encodings (OP_SRA, OP_SRL, OP_SUB, OP_ADD), the FSM state typedef, and the data width constant 4.
REQ-034 The block SHALL instantiate one combinational sub-module, alu_core (a, b, c, op -> ans), with the FIFO, FSM, acc and counter in alu_cmd_issuer.

Verification
REQ-035 The bench SHALL cover: add a=7, b=9 -> out_ans=0 two edges after accept; sub a=3, b=5 -> 4'hE.
REQ-036 The bench SHALL cover: SRA a=4'b1000, c=2 -> 4'b1110; SRL same operands -> 4'b0010.
REQ-037 The bench SHALL cover chaining: add a=3, b=2 -> 5; then chain add b=1 -> 6; then chain sub b=6 -> 0.
REQ-038 The bench SHALL cover backpressure: out_ready=0, push 5 commands with DEPTH=4 -> 4 FIFO plus 1 result held, in_ready=0, out_ans stable; then release -> results in order, done_cnt=5.
REQ-039 The bench SHALL cover clr with FIFO holding 3 commands and in_valid=1 -> no accept that cycle; next cycle out_valid=0, FIFO empty, done_cnt=0, acc=0.
REQ-040 The bench SHALL cover rst_n pulsed low mid-stream with 2 queued commands -> out_valid drops asynchronously, and no stale result appears after release.
